ysyx_22050039_idu_stage: RTL and testbench

Pipelined, parametrised instruction-decode stage for the NPC core: accepts fetched instructions over a valid/ready handshake, classifies the RISC-V format, generates the sign-extended immediate, reads operands from an internal register file and presents a registered decode bundle to EXU. It extends single-cycle decode with a one-entry output pipeline register, a write-back port with same-cycle bypass, a per-register scoreboard that stalls RAW/WAW hazards, and a flush input.

---
 rtl/ysyx_22050039_idu_stage_if.sv | 39 +++
 rtl/ysyx_22050039_idu_stage.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_22050039_idu_stage.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050039_idu_stage_if.sv
// Fetch/decode/write-back signal bundle of the NPC decode stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface ysyx_22050039_idu_stage_if #(
   parameter int XLEN     = 64,
   parameter int INST_LEN = 32,
   parameter int REG_SEL  = 5
);
   logic                in_valid;
   logic                in_ready;
   logic [INST_LEN-1:0] in_inst;
   logic [XLEN-1:0]     in_pc;
   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_pc;
   logic [XLEN-1:0]     out_src1;
   logic [XLEN-1:0]     out_src2;
   logic [XLEN-1:0]     out_imm;
   logic [REG_SEL-1:0]  out_rd;
   logic [5:0]          out_type;
   logic                out_wen;
   logic                out_special;
   logic                out_illegal;
   logic                wb_valid;
   logic [REG_SEL-1:0]  wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic                flush;

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
      output in_ready, out_valid, out_pc, out_src1, out_src2, out_imm, out_rd,
             out_type, out_wen, out_special, out_illegal
   );

   modport master (
      output in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
      input  in_ready, out_valid, out_pc, out_src1, out_src2, out_imm, out_rd,
             out_type, out_wen, out_special, out_illegal
   );
endinterface

// File: rtl/ysyx_22050039_idu_stage.sv
// RISC-V decode stage: format/immediate decode, GPR read with write-back bypass,
// busy-bit scoreboard for RAW/WAW stalls, and a one-entry registered output bundle.
module ysyx_22050039_idu_stage #(
   parameter int XLEN     = 64,
   parameter int INST_LEN = 32,
   parameter int NR_REG   = 32,
   parameter int REG_SEL  = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input logic clk,
   input logic rst,
   ysyx_22050039_idu_stage_if.slave bus
);

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [6:0]         opcode;
   logic [REG_SEL-1:0] rs1, rs2, rd;
   logic               fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j, is_special, is_illegal;
   logic               use_rs1, use_rs2, wen;
   logic [XLEN-1:0]    imm, src1, src2;
   logic [NR_REG-1:0]  wb_clr, busy_eff;
   logic               stall, in_ready_c, accept;

   logic [XLEN-1:0]    regs_q [NR_REG];
   logic [XLEN-1:0]    regs_d [NR_REG];
   logic [NR_REG-1:0]  busy_q, busy_d;
   logic               out_valid_q, out_valid_d;
   logic [XLEN-1:0]    out_pc_q, out_pc_d;
   logic [XLEN-1:0]    out_src1_q, out_src1_d;
   logic [XLEN-1:0]    out_src2_q, out_src2_d;
   logic [XLEN-1:0]    out_imm_q, out_imm_d;
   logic [REG_SEL-1:0] out_rd_q, out_rd_d;
   logic [5:0]         out_type_q, out_type_d;
   logic               out_wen_q, out_wen_d;
   logic               out_special_q, out_special_d;
   logic               out_illegal_q, out_illegal_d;

   always_comb begin
      opcode     = bus.in_inst[6:0];
      rd         = bus.in_inst[7 +: REG_SEL];
      rs1        = bus.in_inst[15 +: REG_SEL];
      rs2        = bus.in_inst[20 +: REG_SEL];
      fmt_r      = 1'b0;
      fmt_i      = 1'b0;
      fmt_s      = 1'b0;
      fmt_b      = 1'b0;
      fmt_u      = 1'b0;
      fmt_j      = 1'b0;
      is_special = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OP_OP, OP_OP32:                      fmt_r      = 1'b1;
         OP_IMM, OP_IMM32, OP_LOAD, OP_JALR:  fmt_i      = 1'b1;
         OP_STORE:                            fmt_s      = 1'b1;
         OP_BRANCH:                           fmt_b      = 1'b1;
         OP_AUIPC, OP_LUI:                    fmt_u      = 1'b1;
         OP_JAL:                              fmt_j      = 1'b1;
         OP_SYSTEM:                           is_special = 1'b1;
         default:                             is_illegal = 1'b1;
      endcase

      imm = '0;
      if (fmt_i) imm = {{(XLEN-12){bus.in_inst[31]}}, bus.in_inst[31:20]};
      if (fmt_s) imm = {{(XLEN-12){bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
      if (fmt_b) imm = {{(XLEN-13){bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                        bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
      if (fmt_u) imm = {{(XLEN-32){bus.in_inst[31]}}, bus.in_inst[31:12], 12'b0};
      if (fmt_j) imm = {{(XLEN-21){bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                        bus.in_inst[20], bus.in_inst[30:21], 1'b0};

      use_rs1 = fmt_r | fmt_i | fmt_s | fmt_b;
      use_rs2 = fmt_r | fmt_s | fmt_b;
      wen     = (fmt_r | fmt_i | fmt_u | fmt_j) & ~(ZERO_REG && rd == '0);
   end

   // Operand read; a write-back landing this cycle is forwarded ahead of the array.
   always_comb begin
      src1 = '0;
      if (use_rs1 && !(ZERO_REG && rs1 == '0)) begin
         if (bus.wb_valid && bus.wb_rd == rs1) src1 = bus.wb_data;
         else                                  src1 = regs_q[rs1];
      end
      src2 = '0;
      if (use_rs2 && !(ZERO_REG && rs2 == '0)) begin
         if (bus.wb_valid && bus.wb_rd == rs2) src2 = bus.wb_data;
         else                                  src2 = regs_q[rs2];
      end
   end

   always_comb begin
      wb_clr = '0;
      if (bus.wb_valid) wb_clr[bus.wb_rd] = 1'b1;
      busy_eff   = busy_q & ~wb_clr;
      stall      = (use_rs1 & busy_eff[rs1]) | (use_rs2 & busy_eff[rs2]) | (wen & busy_eff[rd]);
      in_ready_c = rst & ~bus.flush & ~stall & (~out_valid_q | bus.out_ready);
      accept     = bus.in_valid & in_ready_c;
   end

   always_comb begin
      regs_d = regs_q;
      if (bus.wb_valid && !(ZERO_REG && bus.wb_rd == '0)) regs_d[bus.wb_rd] = bus.wb_data;

      // Clears first so a same-cycle set of the same index wins.
      busy_d = busy_q & ~wb_clr;
      if (bus.flush && out_valid_q && out_wen_q) busy_d[out_rd_q] = 1'b0;
      if (accept && wen) busy_d[rd] = 1'b1;

      out_valid_d   = out_valid_q;
      out_pc_d      = out_pc_q;
      out_src1_d    = out_src1_q;
      out_src2_d    = out_src2_q;
      out_imm_d     = out_imm_q;
      out_rd_d      = out_rd_q;
      out_type_d    = out_type_q;
      out_wen_d     = out_wen_q;
      out_special_d = out_special_q;
      out_illegal_d = out_illegal_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d   = 1'b1;
         out_pc_d      = bus.in_pc;
         out_src1_d    = src1;
         out_src2_d    = src2;
         out_imm_d     = imm;
         out_rd_d      = rd;
         out_type_d    = {fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j};
         out_wen_d     = wen;
         out_special_d = is_special;
         out_illegal_d = is_illegal;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q        <= '{default: '0};
         busy_q        <= '0;
         out_valid_q   <= 1'b0;
         out_pc_q      <= '0;
         out_src1_q    <= '0;
         out_src2_q    <= '0;
         out_imm_q     <= '0;
         out_rd_q      <= '0;
         out_type_q    <= '0;
         out_wen_q     <= 1'b0;
         out_special_q <= 1'b0;
         out_illegal_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         busy_q        <= busy_d;
         out_valid_q   <= out_valid_d;
         out_pc_q      <= out_pc_d;
         out_src1_q    <= out_src1_d;
         out_src2_q    <= out_src2_d;
         out_imm_q     <= out_imm_d;
         out_rd_q      <= out_rd_d;
         out_type_q    <= out_type_d;
         out_wen_q     <= out_wen_d;
         out_special_q <= out_special_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   always_comb begin
      bus.in_ready    = in_ready_c;
      bus.out_valid   = out_valid_q;
      bus.out_pc      = out_pc_q;
      bus.out_src1    = out_src1_q;
      bus.out_src2    = out_src2_q;
      bus.out_imm     = out_imm_q;
      bus.out_rd      = out_rd_q;
      bus.out_type    = out_type_q;
      bus.out_wen     = out_wen_q;
      bus.out_special = out_special_q;
      bus.out_illegal = out_illegal_q;
   end

endmodule

// File: tb/tb_ysyx_22050039_idu_stage.sv
// Scoreboard bench for the decode stage: a pending-destination list models hazards,
// expected bundles are queued at acceptance and checked by an independent monitor.
module tb_ysyx_22050039_idu_stage;
   localparam int XLEN     = 64;
   localparam int INST_LEN = 32;
   localparam int NR_REG   = 32;
   localparam int REG_SEL  = 5;

   typedef struct {
      longint unsigned pc, src1, src2, imm;
      int              rd, rs1, rs2;
      bit [5:0]        typ;
      bit              wen, special, illegal, use1, use2;
   } bundle_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ysyx_22050039_idu_stage_if #(.XLEN(XLEN), .INST_LEN(INST_LEN), .REG_SEL(REG_SEL)) bus ();

   ysyx_22050039_idu_stage #(
      .XLEN(XLEN), .INST_LEN(INST_LEN), .NR_REG(NR_REG), .REG_SEL(REG_SEL), .ZERO_REG(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   bundle_t         exp_q[$];
   int              pend[$];
   int              exu_q[$];
   longint unsigned ref_regs[NR_REG];
   int              errors = 0;
   int              checks = 0;
   bit              had_held = 1'b0;
   bit              rst_s;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint unsigned fld(input bit [31:0] inst, input int lo, input int n);
      longint unsigned w = inst;
      return (w >> lo) & ((64'd1 << n) - 1);
   endfunction

   function automatic longint unsigned sext(input longint unsigned v, input int bits);
      longint unsigned m = 64'd1 << (bits - 1);
      return (v ^ m) - m;
   endfunction

   function automatic bundle_t dec(input bit [31:0] inst);
      bundle_t b;
      b = '{default: 0};
      b.rd  = int'(fld(inst, 7, 5));
      b.rs1 = int'(fld(inst, 15, 5));
      b.rs2 = int'(fld(inst, 20, 5));
      case (fld(inst, 0, 7))
         'h33, 'h3B:             b.typ = 6'b100000;
         'h13, 'h1B, 'h03, 'h67: b.typ = 6'b010000;
         'h23:                   b.typ = 6'b001000;
         'h63:                   b.typ = 6'b000100;
         'h17, 'h37:             b.typ = 6'b000010;
         'h6F:                   b.typ = 6'b000001;
         'h73:                   b.special = 1'b1;
         default:                b.illegal = 1'b1;
      endcase
      case (b.typ)
         6'b010000: b.imm = sext(fld(inst, 20, 12), 12);
         6'b001000: b.imm = sext((fld(inst, 25, 7) << 5) | fld(inst, 7, 5), 12);
         6'b000100: b.imm = sext((fld(inst, 31, 1) << 12) | (fld(inst, 7, 1) << 11) |
                                 (fld(inst, 25, 6) << 5) | (fld(inst, 8, 4) << 1), 13);
         6'b000010: b.imm = sext(fld(inst, 12, 20) << 12, 32);
         6'b000001: b.imm = sext((fld(inst, 31, 1) << 20) | (fld(inst, 12, 8) << 12) |
                                 (fld(inst, 20, 1) << 11) | (fld(inst, 21, 10) << 1), 21);
         default:   b.imm = 0;
      endcase
      b.use1 = b.typ inside {6'b100000, 6'b010000, 6'b001000, 6'b000100};
      b.use2 = b.typ inside {6'b100000, 6'b001000, 6'b000100};
      b.wen  = (b.typ inside {6'b100000, 6'b010000, 6'b000010, 6'b000001}) && b.rd != 0;
      return b;
   endfunction

   function automatic bit in_pend(input int r);
      foreach (pend[i]) if (pend[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void pend_remove(input int r);
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i] == r) pend.delete(i);
   endfunction

   function automatic longint unsigned rdval(input int r, input bit wbv, input int wbrd,
                                             input longint unsigned wbd);
      if (r == 0) return 0;
      if (wbv && wbrd == r) return wbd;
      return ref_regs[r];
   endfunction

   function automatic bit [31:0] rand_inst();
      bit [31:0] ops [12] = '{32'h33, 32'h3B, 32'h13, 32'h1B, 32'h03, 32'h67,
                              32'h23, 32'h63, 32'h17, 32'h37, 32'h6F, 32'h73};
      bit [31:0] w = $urandom;
      int k = $urandom_range(12, 0);
      w[6:0]   = (k < 12) ? ops[k][6:0] : w[6:0];
      w[11:7]  = 5'($urandom_range(7, 0));
      w[19:15] = 5'($urandom_range(7, 0));
      w[24:20] = 5'($urandom_range(7, 0));
      return w;
   endfunction

   // One clock cycle: drive at +1, evaluate the reference model at +6.
   task automatic cycle(input bit r, input bit v, input bit [31:0] inst, input longint unsigned pc,
                        input bit ordy, input bit fl, input bit wbv, input int wbrd,
                        input longint unsigned wbd, input bit auto_wb);
      bundle_t d;
      bit held, busy1, busy2, busyd, stall, exp_ready;
      @(posedge clk);
      #1;
      if (auto_wb) begin
         wbv = 1'b0;
         if (exu_q.size() > 0 && $urandom_range(1, 0) == 1) begin
            wbv  = 1'b1;
            wbrd = exu_q.pop_front();
            wbd  = {$urandom, $urandom};
         end else if ($urandom_range(7, 0) == 0) begin
            wbrd = $urandom_range(7, 0);
            if (!in_pend(wbrd)) begin
               wbv = 1'b1;
               wbd = {$urandom, $urandom};
            end
         end
      end
      rst           = r;
      bus.in_valid  = v;
      bus.in_inst   = inst;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      bus.flush     = fl;
      bus.wb_valid  = wbv;
      bus.wb_rd     = REG_SEL'(wbrd);
      bus.wb_data   = wbd;
      #5;
      held     = exp_q.size() > 0;
      had_held = held;
      if (!r) begin
         check("in_ready_in_reset", bus.in_ready, 0);
         pend.delete();
         exu_q.delete();
         foreach (ref_regs[i]) ref_regs[i] = 0;
         return;
      end
      d     = dec(inst);
      busy1 = in_pend(d.rs1) && !(wbv && wbrd == d.rs1);
      busy2 = in_pend(d.rs2) && !(wbv && wbrd == d.rs2);
      busyd = in_pend(d.rd) && !(wbv && wbrd == d.rd);
      stall = (d.use1 && busy1) || (d.use2 && busy2) || (d.wen && busyd);
      exp_ready = !fl && !stall && (!held || ordy);
      check("in_ready", bus.in_ready, exp_ready);
      if (v && exp_ready) begin
         d.pc   = pc;
         d.src1 = d.use1 ? rdval(d.rs1, wbv, wbrd, wbd) : 0;
         d.src2 = d.use2 ? rdval(d.rs2, wbv, wbrd, wbd) : 0;
         exp_q.push_back(d);
      end
      if (fl && held && exp_q[0].wen) pend_remove(exp_q[0].rd);
      if (wbv) begin
         pend_remove(wbrd);
         if (wbrd != 0) ref_regs[wbrd] = wbd;
      end
      if (v && exp_ready && d.wen) pend.push_back(d.rd);
   endtask

   // Monitor: compare presented bundle at +3, retire it at +8 once consumed or flushed.
   initial begin
      bundle_t b;
      forever begin
         @(posedge clk);
         rst_s = rst;
         #3;
         if (!rst_s) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_pc", bus.out_pc, 0);
            check("rst_out_src", bus.out_src1 | bus.out_src2, 0);
            check("rst_out_imm", bus.out_imm, 0);
            check("rst_out_ctl", {bus.out_rd, bus.out_type, bus.out_wen, bus.out_special,
                                  bus.out_illegal}, 0);
         end else begin
            check("out_valid", bus.out_valid, exp_q.size() != 0);
            if (bus.out_valid === 1'b1 && exp_q.size() != 0) begin
               b = exp_q[0];
               check("out_pc", bus.out_pc, b.pc);
               check("out_src1", bus.out_src1, b.src1);
               check("out_src2", bus.out_src2, b.src2);
               check("out_imm", bus.out_imm, b.imm);
               check("out_rd", bus.out_rd, 64'(b.rd));
               check("out_type", bus.out_type, 64'(b.typ));
               check("out_flags", {bus.out_wen, bus.out_special, bus.out_illegal},
                     {b.wen, b.special, b.illegal});
            end
         end
         #5;
         if (!rst) begin
            exp_q.delete();
         end else if (had_held) begin
            if (bus.flush) begin
               void'(exp_q.pop_front());
            end else if (bus.out_ready) begin
               b = exp_q.pop_front();
               if (b.wen) exu_q.push_back(b.rd);
            end
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
      bus.flush = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      // reset with a valid instruction offered
      repeat (2) cycle(0, 1, 32'hFFF00093, 64'h80000000, 1, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h00528333, 64'h80000000, 1, 0, 0, 0, 0, 0);   // add x6,x5,x5
      cycle(1, 1, 32'hFFF00093, 64'h80000004, 1, 0, 0, 0, 0, 0);   // addi x1,x0,-1
      cycle(1, 1, 32'h00108133, 64'h80000008, 1, 0, 0, 0, 0, 0);   // add x2,x1,x1 stalls
      cycle(1, 1, 32'h00108133, 64'h80000008, 1, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h00108133, 64'h80000008, 1, 0, 1, 1, 7, 0);   // wb x1=7 releases it
      cycle(1, 1, 32'hFFDFF0EF, 64'h8000000C, 1, 0, 0, 0, 0, 0);   // jal x1,-4
      repeat (3) cycle(1, 1, 32'h00100493, 64'h80000010, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 32'h00100493, 64'h80000010, 1, 0, 0, 0, 0, 0);   // addi x9
      cycle(1, 1, 32'h00500193, 64'h80000014, 1, 0, 0, 0, 0, 0);   // addi x3
      cycle(1, 0, 32'h0, 64'h0, 0, 1, 0, 0, 0, 0);                  // flush held x3
      cycle(1, 1, 32'h00318233, 64'h80000018, 1, 0, 0, 0, 0, 0);   // add x4,x3,x3
      cycle(1, 0, 32'h0, 64'h0, 1, 0, 1, 0, 5, 0);                  // wb x0
      cycle(1, 1, 32'h000003B3, 64'h8000001C, 1, 0, 1, 0, 5, 0);   // add x7,x0,x0
      cycle(1, 0, 32'h0, 64'h0, 1, 0, 1, 5, 64'h1234, 0);           // wb x5
      cycle(1, 1, 32'h00528433, 64'h80000020, 1, 0, 0, 0, 0, 0);   // add x8,x5,x5
      cycle(1, 1, 32'h0000007F, 64'h80000024, 1, 0, 0, 0, 0, 0);   // illegal
      cycle(1, 1, 32'h00100073, 64'h80000028, 1, 0, 0, 0, 0, 0);   // ebreak
      cycle(1, 0, 32'h0, 64'h0, 1, 0, 0, 0, 0, 0);
      repeat (2) cycle(0, 0, 32'h0, 64'h0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(499, 0) != 0, $urandom_range(3, 0) != 0, rand_inst(),
               {$urandom, $urandom}, $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0,
               0, 0, 0, 1);
      end
      @(posedge clk);
      #4;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
